// File: rtl/cont_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cont_pkg                                                             |
// | Shared types and constants for the transition-counter bank master:   |
// | bus FSM state encoding, bank data width, default parameter values.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package cont_pkg;

  localparam int C_DATA_W       = 32;
  localparam int C_NUM_CNTR_DEF = 3;
  localparam int C_DIR_W_DEF    = 2;
  localparam int C_PEND_W_DEF   = 4;

  typedef enum logic [2:0] {
    REPOSO    = 3'd0,
    LECTURA   = 3'd1,
    ESCRITURA = 3'd2,
    LIBERA    = 3'd3,
    BORRA_ESC = 3'd4,
    BORRA_LIB = 3'd5
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/detector_transicion.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | detector_transicion                                                  |
// | One monitored channel: edge detector plus saturating pending count.  |
// |   clk, rst_n  : clock, synchronous active-low reset                  |
// |   senal       : monitored signal (already synchronous to clk)        |
// |   recarga     : snapshot taken by the master; count reloads with the |
// |                 edge of this cycle so it is not lost                 |
// |   borra       : bank clear starting; count reloads with this cycle's |
// |                 edge and the overflow flag is cleared                |
// |   pendiente   : transitions not yet added into the bank              |
// |   desborde    : sticky, an edge arrived while the count was full     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module detector_transicion
  import cont_pkg::*;
#(
  parameter int PEND_W = C_PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              senal,
  input  logic              recarga,
  input  logic              borra,
  output logic [PEND_W-1:0] pendiente,
  output logic              desborde
);

  localparam logic [PEND_W-1:0] C_MAX = '1;

  logic              r_prev;
  logic [PEND_W-1:0] r_pend;
  logic              r_desb;
  logic              w_flanco;
  logic [PEND_W-1:0] w_flanco_ext;

  assign w_flanco     = senal ^ r_prev;
  assign w_flanco_ext = {{(PEND_W-1){1'b0}}, w_flanco};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // prev tracks the input even in reset: no false edge on release
      r_prev <= senal;
      r_pend <= '0;
      r_desb <= 1'b0;
    end else begin
      r_prev <= senal;
      if (borra) begin
        r_pend <= w_flanco_ext;
        r_desb <= 1'b0;
      end else if (recarga) begin
        r_pend <= w_flanco_ext;
      end else if (w_flanco) begin
        if (r_pend == C_MAX) r_desb <= 1'b1;
        else                 r_pend <= r_pend + 1'b1;
      end
    end
  end

  assign pendiente = r_pend;
  assign desborde  = r_desb;

endmodule
`default_nettype wire

// File: rtl/maestro_contadores.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maestro_contadores                                                   |
// | Sole master of the transition-counter bank. Counts transitions of    |
// | NUM_CNTR signals locally and folds them into the bank with           |
// | read-modify-write sequences; clears the bank on request.             |
// |   clk, rst_n : clock, synchronous active-low reset                   |
// |   senal      : monitored signals                                     |
// |   clr        : one-cycle pulse, zero every bank counter              |
// |   dir        : bank address                                          |
// |   LE         : 1 = bank drives dato (read), 0 = master writes        |
// |   dato       : bank data, driven by the master only while LE=0       |
// |   ocupado    : sequence running or clear pending                     |
// |   desborde   : sticky per-channel pending-counter overflow           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module maestro_contadores
  import cont_pkg::*;
#(
  parameter int NUM_CNTR = C_NUM_CNTR_DEF,
  parameter int DIR_W    = C_DIR_W_DEF,
  parameter int PEND_W   = C_PEND_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CNTR-1:0] senal,
  input  logic                clr,
  output logic [DIR_W-1:0]    dir,
  output logic                LE,
  inout  wire  [C_DATA_W-1:0] dato,
  output logic                ocupado,
  output logic [NUM_CNTR-1:0] desborde
);

  localparam logic [DIR_W-1:0] C_ULT = DIR_W'(NUM_CNTR - 1);

  estado_t             r_estado;
  estado_t             w_estado_sig;
  logic [DIR_W-1:0]    r_dir;
  logic [DIR_W-1:0]    r_ch;
  logic [DIR_W-1:0]    r_rr;
  logic [PEND_W-1:0]   r_snap;
  logic [C_DATA_W-1:0] r_rdata;
  logic                r_clr_req;

  logic [PEND_W-1:0]   w_pend [NUM_CNTR];
  logic [NUM_CNTR-1:0] w_nz;
  logic [NUM_CNTR-1:0] w_recarga;
  logic                w_borra;
  logic                w_hay;
  logic                w_hay_alto;
  logic [DIR_W-1:0]    w_sel;
  logic [DIR_W-1:0]    w_sel_alto;
  logic [DIR_W-1:0]    w_sel_bajo;
  logic                w_le;
  logic [C_DATA_W-1:0] w_wdata;

  generate
    for (genvar i = 0; i < NUM_CNTR; i++) begin : g_canal
      detector_transicion #(
        .PEND_W (PEND_W)
      ) u_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .senal     (senal[i]),
        .recarga   (w_recarga[i]),
        .borra     (w_borra),
        .pendiente (w_pend[i]),
        .desborde  (desborde[i])
      );
      assign w_nz[i] = |w_pend[i];
    end
  endgenerate

  // Round-robin pick: lowest pending channel at or above rr_ptr, else the
  // lowest pending channel overall (wrap). Scanning downward lets the
  // lowest index be the last assignment.
  always_comb begin
    w_hay      = 1'b0;
    w_hay_alto = 1'b0;
    w_sel_alto = '0;
    w_sel_bajo = '0;
    for (int i = NUM_CNTR - 1; i >= 0; i--) begin
      if (w_nz[i]) begin
        w_hay      = 1'b1;
        w_sel_bajo = DIR_W'(i);
        if (DIR_W'(i) >= r_rr) begin
          w_hay_alto = 1'b1;
          w_sel_alto = DIR_W'(i);
        end
      end
    end
    w_sel = w_hay_alto ? w_sel_alto : w_sel_bajo;
  end

  // Clear wins over updates, so a snapshot is only taken without a request
  assign w_borra   = (r_estado == REPOSO) && r_clr_req;
  assign w_recarga = ((r_estado == REPOSO) && !r_clr_req && w_hay)
                     ? (NUM_CNTR'(1) << w_sel) : '0;

  always_comb begin
    w_estado_sig = r_estado;
    w_le         = 1'b1;
    case (r_estado)
      REPOSO: begin
        if (r_clr_req)  w_estado_sig = BORRA_ESC;
        else if (w_hay) w_estado_sig = LECTURA;
      end
      LECTURA:   w_estado_sig = ESCRITURA;
      ESCRITURA: begin
        w_le         = 1'b0;
        w_estado_sig = LIBERA;
      end
      LIBERA:    w_estado_sig = REPOSO;
      BORRA_ESC: begin
        w_le         = 1'b0;
        w_estado_sig = BORRA_LIB;
      end
      BORRA_LIB: w_estado_sig = (r_dir == C_ULT) ? REPOSO : BORRA_ESC;
      default:   w_estado_sig = REPOSO;
    endcase
  end

  // dir only moves on edges leaving REPOSO or BORRA_LIB, where LE is high,
  // so the level-transparent write port never sees an address change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado  <= REPOSO;
      r_dir     <= '0;
      r_ch      <= '0;
      r_rr      <= '0;
      r_snap    <= '0;
      r_rdata   <= '0;
      r_clr_req <= 1'b0;
    end else begin
      r_estado <= w_estado_sig;
      case (r_estado)
        REPOSO: begin
          if (r_clr_req) begin
            r_dir <= '0;
          end else if (w_hay) begin
            r_ch   <= w_sel;
            r_dir  <= w_sel;
            r_snap <= w_pend[w_sel];
          end
        end
        LECTURA:   r_rdata <= dato;
        LIBERA:    r_rr    <= (r_ch == C_ULT) ? '0 : r_ch + 1'b1;
        BORRA_LIB: if (r_dir != C_ULT) r_dir <= r_dir + 1'b1;
        default: ;
      endcase
      // A new pulse on the final clear cycle starts another clear
      if (clr)
        r_clr_req <= 1'b1;
      else if ((r_estado == BORRA_LIB) && (r_dir == C_ULT))
        r_clr_req <= 1'b0;
    end
  end

  // Sum wraps modulo 2^32 by truncation
  assign w_wdata = (r_estado == ESCRITURA) ? (r_rdata + C_DATA_W'(r_snap)) : '0;

  assign dato    = w_le ? 'z : w_wdata;
  assign LE      = w_le;
  assign dir     = r_dir;
  assign ocupado = (r_estado != REPOSO) | r_clr_req;

endmodule
`default_nettype wire

// File: tb/tb_maestro_contadores.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_maestro_contadores                                                |
// | Directed bench: behavioural counter bank on the dir/LE/dato bus, a   |
// | bus-rule watcher, and hand-computed write sequences per scenario.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_maestro_contadores;

  localparam int NUM_CNTR = 3;
  localparam int DIR_W    = 2;
  // Narrow pending counters (max 3) so saturation is reachable in the gap
  // between two services of a channel.
  localparam int PEND_W   = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NUM_CNTR-1:0] senal;
  logic                clr;
  logic [DIR_W-1:0]    dir;
  logic                LE;
  wire  [31:0]         dato;
  logic                ocupado;
  logic [NUM_CNTR-1:0] desborde;

  int errors = 0;
  int checks = 0;

  logic [31:0] bank [0:3];
  logic        pre_we = 1'b0;
  logic [1:0]  pre_a  = '0;
  logic [31:0] pre_d  = '0;
  logic [33:0] wq [$];
  logic        last_le  = 1'b1;
  logic [1:0]  last_dir = '0;

  maestro_contadores #(
    .NUM_CNTR (NUM_CNTR),
    .DIR_W    (DIR_W),
    .PEND_W   (PEND_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .senal    (senal),
    .clr      (clr),
    .dir      (dir),
    .LE       (LE),
    .dato     (dato),
    .ocupado  (ocupado),
    .desborde (desborde)
  );

  always #5 clk = ~clk;

  // Bank model: drives dato on reads, latches writes while LE is low
  assign dato = LE ? bank[dir] : 32'bz;

  always @(posedge clk) begin
    if (pre_we)              bank[pre_a] <= pre_d;
    else if (rst_n && !LE)   bank[dir]   <= dato;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus watcher and write log, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (!last_le) begin
        check("dir_hold", 32'(dir), 32'(last_dir));
        check("le_pulse", 32'(LE), 32'd1);
      end
      if (LE) check("no_drive", dato, bank[dir]);
      else    wq.push_back({dir, dato});
    end
    last_le  = LE;
    last_dir = dir;
  end

  task automatic preload(input logic [1:0] a, input logic [31:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    for (int i = 0; i < 300 && quiet < 4; i++) begin
      @(negedge clk);
      quiet = ocupado ? 0 : quiet + 1;
    end
    check({tag, "_idle"}, 32'(quiet >= 4), 32'd1);
  endtask

  task automatic expect_wr(input string tag, input logic [1:0] d, input logic [31:0] v);
    logic [33:0] e;
    if (wq.size() == 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      e = wq.pop_front();
      check({tag, "_dir"}, 32'(e[33:32]), 32'(d));
      check({tag, "_dato"}, e[31:0], v);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n = 1'b0; senal = '0; clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_le", 32'(LE), 32'd1);
    check("rst_dir", 32'(dir), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_desborde", 32'(desborde), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    preload(2'd0, 32'd5);
    preload(2'd1, 32'd10);
    preload(2'd2, 32'd0);
    wq.delete();

    // Single transition on ch0: 5 -> 6
    senal[0] = ~senal[0];
    wait_idle("t1");
    expect_wr("t1_w", 2'd0, 32'd6);
    check("t1_nmore", 32'(wq.size()), 32'd0);
    check("t1_bank0", bank[0], 32'd6);

    // Burst: 3 edges on ch1 while ch0 is serviced, 1 more during LECTURA
    senal[0] = ~senal[0];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      senal[1] = ~senal[1];
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ocupado && LE && dir == 2'd1) found = 1'b1;
    end
    check("t2_lectura_seen", 32'(found), 32'd1);
    senal[1] = ~senal[1];
    wait_idle("t2");
    expect_wr("t2_w0", 2'd0, 32'd7);
    expect_wr("t2_w1", 2'd1, 32'd13);
    expect_wr("t2_w2", 2'd1, 32'd14);
    check("t2_nmore", 32'(wq.size()), 32'd0);
    check("t2_bank1", bank[1], 32'd14);

    // Wrap modulo 2^32
    @(posedge clk); #1;
    preload(2'd2, 32'hFFFF_FFFF);
    senal[2] = ~senal[2];
    wait_idle("t3");
    expect_wr("t3_w", 2'd2, 32'h0000_0000);
    check("t3_bank2", bank[2], 32'h0000_0000);

    // Saturation on ch0 while ch1 and ch2 hold the bus
    @(posedge clk); #1;
    preload(2'd0, 32'd100);
    preload(2'd1, 32'd200);
    preload(2'd2, 32'd300);
    wq.delete();
    senal[1] = ~senal[1];
    senal[2] = ~senal[2];
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      senal[0] = ~senal[0];
    end
    wait_idle("t4");
    expect_wr("t4_w1", 2'd1, 32'd201);
    expect_wr("t4_w2", 2'd2, 32'd301);
    expect_wr("t4_w0", 2'd0, 32'd103);
    check("t4_desborde", 32'(desborde), 32'b001);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    wait_idle("t4c");
    expect_wr("t4_c0", 2'd0, 32'd0);
    expect_wr("t4_c1", 2'd1, 32'd0);
    expect_wr("t4_c2", 2'd2, 32'd0);
    check("t4_desb_clr", 32'(desborde), 32'b000);

    // Clear requested during the ch1 write
    @(posedge clk); #1;
    preload(2'd0, 32'd7);
    preload(2'd1, 32'd50);
    preload(2'd2, 32'd9);
    wq.delete();
    senal[1] = ~senal[1];
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!LE) found = 1'b1;
    end
    check("t5_esc_seen", 32'(found), 32'd1);
    check("t5_ocup_esc", 32'(ocupado), 32'd1);
    clr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) clr = 1'b0;
      check($sformatf("t5_ocup%0d", k), 32'(ocupado), 32'd1);
    end
    @(negedge clk);
    check("t5_ocup_end", 32'(ocupado), 32'd0);
    expect_wr("t5_w1", 2'd1, 32'd51);
    expect_wr("t5_c0", 2'd0, 32'd0);
    expect_wr("t5_c1", 2'd1, 32'd0);
    expect_wr("t5_c2", 2'd2, 32'd0);
    check("t5_nmore", 32'(wq.size()), 32'd0);
    check("t5_bank0", bank[0], 32'd0);
    check("t5_bank1", bank[1], 32'd0);
    check("t5_bank2", bank[2], 32'd0);

    // Reset in the middle of LECTURA
    @(posedge clk); #1;
    preload(2'd0, 32'd40);
    wq.delete();
    senal[0] = ~senal[0];
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ocupado) found = 1'b1;
    end
    check("t6_lectura_seen", 32'(found), 32'd1);
    check("t6_lectura_le", 32'(LE), 32'd1);
    rst_n = 1'b0;
    senal[0] = ~senal[0];
    @(negedge clk);
    check("t6_le", 32'(LE), 32'd1);
    check("t6_ocupado", 32'(ocupado), 32'd0);
    check("t6_dato", dato, 32'd40);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_nowrite", 32'(wq.size()), 32'd0);
    check("t6_ocup_after", 32'(ocupado), 32'd0);
    check("t6_bank0", bank[0], 32'd40);
    check("t6_desborde", 32'(desborde), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
